// File: rtl/n_bit_compare_tracker.sv
// n_bit_compare_tracker
// Compares two unsigned operands under a selectable relation once per sample.
// The result is registered with one cycle of latency. The block also tracks
// the total number of true results and the current run of consecutive true
// results. A three-state FSM reports when that run reaches LOCK_LEN.
module n_bit_compare_tracker #(
   parameter int WIDTH    = 8,
   parameter int CNT_W    = 8,
   parameter int LOCK_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   output logic             c,
   output logic             eq,
   output logic [CNT_W-1:0] match_cnt,
   output logic             locked
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      TRACK  = 2'b01,
      LOCKED = 2'b10
   } state_t;

   // The streak never needs to count past LOCK_LEN, which fits in 8 bits.
   localparam logic [7:0]       LOCK_V  = 8'(LOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [7:0]       streak_q, streak_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             c_q, c_d;
   logic             eq_q, eq_d;
   logic             cmp_s;
   logic             eq_s;

   // Evaluate the relation selected by mode on the raw operands.
   always_comb begin
      eq_s  = (a == b);
      cmp_s = 1'b0;
      case (mode)
         2'b00:   cmp_s = (a == b);
         2'b01:   cmp_s = (a != b);
         2'b10:   cmp_s = (a <  b);
         2'b11:   cmp_s = (a >  b);
         default: cmp_s = 1'b0;
      endcase
   end

   // Compute the next state: clear wins, then a sample, otherwise hold.
   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      match_cnt_d = match_cnt_q;
      out_valid_d = 1'b0;
      c_d         = c_q;
      eq_d        = eq_q;
      if (clr) begin
         // A sample arriving in the same cycle as clr is discarded.
         state_d     = IDLE;
         streak_d    = 8'd0;
         match_cnt_d = {CNT_W{1'b0}};
         c_d         = 1'b0;
         eq_d        = 1'b0;
      end else if (in_valid) begin
         out_valid_d = 1'b1;
         c_d         = cmp_s;
         eq_d        = eq_s;
         if (cmp_s) begin
            if (match_cnt_q != CNT_MAX) begin
               match_cnt_d = match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               match_cnt_d = match_cnt_q;
            end
            if (streak_q < LOCK_V) begin
               streak_d = streak_q + 8'd1;
            end else begin
               streak_d = streak_q;
            end
         end else begin
            streak_d = 8'd0;
         end
         case (state_q)
            IDLE: begin
               if (streak_d == LOCK_V) begin
                  state_d = LOCKED;
               end else begin
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (streak_d == LOCK_V) begin
                  state_d = LOCKED;
               end else begin
                  state_d = TRACK;
               end
            end
            LOCKED: begin
               if (cmp_s) begin
                  state_d = LOCKED;
               end else begin
                  state_d = TRACK;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         // Idle cycle: results hold and the streak is untouched.
         state_d = state_q;
      end
   end

   // Register all state; rst clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         streak_q    <= 8'd0;
         match_cnt_q <= {CNT_W{1'b0}};
         out_valid_q <= 1'b0;
         c_q         <= 1'b0;
         eq_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         match_cnt_q <= match_cnt_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         eq_q        <= eq_d;
      end
   end

   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign eq        = eq_q;
   assign match_cnt = match_cnt_q;
   assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_n_bit_compare_tracker.sv
// Testbench for n_bit_compare_tracker (WIDTH=8, CNT_W=8, LOCK_LEN=4).
// A table of mode-sweep vectors is followed by hand-written multi-cycle
// sequences. A scoreboard queue holds the expected {c,eq} for every sample.
module tb_n_bit_compare_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [1:0] mode = 2'b00;
   logic       out_valid;
   logic       c;
   logic       eq;
   logic [7:0] match_cnt;
   logic       locked;

   int tests = 0;
   int fails = 0;
   logic [1:0] sb_q[$];

   typedef struct {
      logic [1:0] m;
      logic [7:0] va;
      logic [7:0] vb;
      logic       ec;
      logic       ee;
   } vec_t;

   vec_t vecs[12];

   n_bit_compare_tracker #(.WIDTH(8), .CNT_W(8), .LOCK_LEN(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .a(a), .b(b), .mode(mode),
      .out_valid(out_valid), .c(c), .eq(eq),
      .match_cnt(match_cnt), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every out_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      logic [1:0] e;
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("c", {31'd0, c}, {31'd0, e[1]});
            check("eq", {31'd0, eq}, {31'd0, e[0]});
         end
      end
   end

   task automatic send(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                       input logic ec, input logic ee);
      in_valid = 1'b1; mode = m; a = va; b = vb;
      sb_q.push_back({ec, ee});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b00, 8'h05, 8'h05, 1'b1, 1'b1};
      vecs[1]  = '{2'b01, 8'h05, 8'h05, 1'b0, 1'b1};
      vecs[2]  = '{2'b10, 8'h05, 8'h05, 1'b0, 1'b1};
      vecs[3]  = '{2'b11, 8'h05, 8'h05, 1'b0, 1'b1};
      vecs[4]  = '{2'b00, 8'h05, 8'h06, 1'b0, 1'b0};
      vecs[5]  = '{2'b01, 8'h05, 8'h06, 1'b1, 1'b0};
      vecs[6]  = '{2'b10, 8'h05, 8'h06, 1'b1, 1'b0};
      vecs[7]  = '{2'b11, 8'h05, 8'h06, 1'b0, 1'b0};
      vecs[8]  = '{2'b00, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[9]  = '{2'b01, 8'hFF, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{2'b10, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[11] = '{2'b11, 8'hFF, 8'h00, 1'b1, 1'b0};

      // Reset state
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_c", {31'd0, c}, 32'd0);
      check("rst_eq", {31'd0, eq}, 32'd0);
      check("rst_match_cnt", {24'd0, match_cnt}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Mode sweep, back to back
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].m, vecs[i].va, vecs[i].vb, vecs[i].ec, vecs[i].ee);
      end
      idle(1);
      check("sweep_idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("sweep_match_cnt", {24'd0, match_cnt}, 32'd5);
      check("sweep_locked", {31'd0, locked}, 32'd0);

      // Clear
      do_clr();
      check("clr_match_cnt", {24'd0, match_cnt}, 32'd0);
      check("clr_c", {31'd0, c}, 32'd0);
      check("clr_eq", {31'd0, eq}, 32'd0);
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);

      // Lock after 4 consecutive matches, unlock on a miss
      for (int i = 0; i < 4; i++) begin
         send(2'b00, 8'h3C, 8'h3C, 1'b1, 1'b1);
         if (i == 2) check("lock_early", {31'd0, locked}, 32'd0);
      end
      check("lock_rise", {31'd0, locked}, 32'd1);
      check("lock_match_cnt", {24'd0, match_cnt}, 32'd4);
      send(2'b00, 8'h3C, 8'h3D, 1'b0, 1'b0);
      check("unlock", {31'd0, locked}, 32'd0);
      check("unlock_match_cnt", {24'd0, match_cnt}, 32'd4);

      // Gaps between matches do not break the streak
      do_clr();
      send(2'b00, 8'h11, 8'h11, 1'b1, 1'b1);
      send(2'b00, 8'h22, 8'h22, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("gap_out_valid", {31'd0, out_valid}, 32'd0);
         check("gap_c_held", {31'd0, c}, 32'd1);
      end
      send(2'b00, 8'h33, 8'h33, 1'b1, 1'b1);
      check("gap_not_locked", {31'd0, locked}, 32'd0);
      send(2'b00, 8'h44, 8'h44, 1'b1, 1'b1);
      check("gap_locked", {31'd0, locked}, 32'd1);

      // Saturation of match_cnt
      do_clr();
      for (int i = 0; i < 260; i++) begin
         send(2'b11, 8'h80, 8'h7F, 1'b1, 1'b0);
         if (i == 254) check("sat_at_255", {24'd0, match_cnt}, 32'd255);
      end
      check("sat_match_cnt", {24'd0, match_cnt}, 32'd255);
      check("sat_locked", {31'd0, locked}, 32'd1);

      // clr beats a coincident sample while locked
      clr = 1'b1; in_valid = 1'b1; mode = 2'b00; a = 8'h55; b = 8'h55;
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      check("prio_out_valid", {31'd0, out_valid}, 32'd0);
      check("prio_match_cnt", {24'd0, match_cnt}, 32'd0);
      check("prio_locked", {31'd0, locked}, 32'd0);

      // Async reset while locked, with a sample in flight
      for (int i = 0; i < 4; i++) send(2'b10, 8'h01, 8'h02, 1'b1, 1'b0);
      check("pre_rst_locked", {31'd0, locked}, 32'd1);
      in_valid = 1'b1; mode = 2'b00; a = 8'h09; b = 8'h09;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_c", {31'd0, c}, 32'd0);
      check("arst_eq", {31'd0, eq}, 32'd0);
      check("arst_match_cnt", {24'd0, match_cnt}, 32'd0);
      check("arst_locked", {31'd0, locked}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      idle(1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      send(2'b00, 8'hA5, 8'hA5, 1'b1, 1'b1);
      check("post_rst_match_cnt", {24'd0, match_cnt}, 32'd1);
      check("post_rst_locked", {31'd0, locked}, 32'd0);

      idle(2);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/n_bit_compare_tracker.md
N_BIT_COMPARE_TRACKER -- requirements
Module: n_bit_compare_tracker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1 to 64).
REQ-002 The module SHALL have parameter CNT_W, default 8, match counter width in bits.
REQ-003 The module SHALL have parameter LOCK_LEN, default 4, number of consecutive sampled true results needed to lock (legal range 1 to 255).
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port clr, input, 1 bit: synchronous clear of counters and state.
REQ-007 The module SHALL have port in_valid, input, 1 bit: a, b and mode are sampled this cycle.
REQ-008 The module SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-009 The module SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-010 The module SHALL have port mode, input, 2 bits: compare select; 00 a==b, 01 a!=b, 10 a<b, 11 a>b.
REQ-011 The module SHALL have port out_valid, output, 1 bit: c and eq hold a new result this cycle.
REQ-012 The module SHALL have port c, output, 1 bit: registered compare result for the selected mode.
REQ-013 The module SHALL have port eq, output, 1 bit: registered a==b for every sample, whatever the mode.
REQ-014 The module SHALL have port match_cnt, output, CNT_W bits: total sampled results with c=1.
REQ-015 The module SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.

Function
REQ-016 Latency SHALL be 1 cycle: a sample taken on edge N drives out_valid=1 with the matching c and eq after edge N, for exactly one cycle.
REQ-017 With in_valid=0, out_valid SHALL be 0 and c and eq SHALL hold their last values.
REQ-018 Comparisons SHALL be unsigned, full WIDTH; no truncation or sign extension.
REQ-019 match_cnt SHALL increment by 1 on each sample with c=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-020 The internal streak counter SHALL increment on each sample with c=1, SHALL go to 0 on a sample with c=0, SHALL ignore in_valid=0 cycles and SHALL saturate at LOCK_LEN.
REQ-021 The FSM SHALL have exactly three states: IDLE, TRACK and LOCKED.
REQ-022 IDLE SHALL go to TRACK on the first sample; if that sample brings streak to LOCK_LEN (possible only when LOCK_LEN=1), it SHALL go directly to LOCKED.
REQ-023 TRACK SHALL go to LOCKED on the sample that brings streak to LOCK_LEN, so locked rises in the same cycle as that sample's out_valid.
REQ-024 LOCKED SHALL go to TRACK on any sample with c=0, so locked falls in the same cycle as that sample's out_valid; LOCKED SHALL be held on samples with c=1.
REQ-025 Changing mode between samples SHALL NOT reset streak, match_cnt or state; each sample is judged by its own mode.
REQ-026 clr=1 SHALL on the next edge set match_cnt=0, streak=0, state=IDLE, out_valid=0, c=0 and eq=0.
REQ-027 clr SHALL take priority over in_valid in the same cycle, and the coincident sample SHALL be discarded.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force out_valid=0, c=0, eq=0, match_cnt=0, locked=0, streak=0 and state=IDLE.
REQ-029 A sample in flight when rst asserts SHALL be lost, and no out_valid SHALL appear for it after rst is released.
REQ-030 The first edge after rst deasserts SHALL sample normally when in_valid=1.

Verification (WIDTH=8, CNT_W=8, LOCK_LEN=4)
REQ-031 Mode sweep: (a,b) = (0x05,0x05), (0x05,0x06) and (0xFF,0x00) under each mode -> c follows the REQ-010 table, eq=1 only for 0x05/0x05, and out_valid is high one cycle after each sample.
REQ-032 Lock: 4 back-to-back samples mode=00, a=b=0x3C -> locked rises with the 4th out_valid and match_cnt=4; then sample a=0x3C, b=0x3D -> locked=0, match_cnt=4.
REQ-033 Gaps: 2 matches, 3 idle cycles, then 2 matches -> locked rises with the 4th match; out_valid=0 and c held during the gaps.
REQ-034 Saturation: 260 matching samples -> match_cnt stops at 255 and locked stays 1.
REQ-035 Priority: clr=1 and in_valid=1 in the same cycle while LOCKED -> next cycle out_valid=0, match_cnt=0, locked=0, and the sample is not counted.
REQ-036 Async reset: assert rst mid-cycle while locked=1 -> all outputs 0 before the next clk edge; deassert rst and send one matching sample -> match_cnt=1, locked=0.
